alu_mul_seq: RTL and testbench

Sequential 16×16 unsigned shift-and-add multiplier that runs on the shared 16-bit ALU. It sits beside alu_16 in the execute stage. It drives the ALU's aluop, a and b inputs and consumes its result, one addition per cycle. It returns a 32-bit product and lets the datapath reuse the existing adder instead of instantiating a multiplier array.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_16.sv | 30 +++
 rtl/alu_mul_seq.sv | 136 +++++++++++++
 tb/tb_alu_mul_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings for alu_16 and the alu_mul_seq FSM states.
package alu_pkg;

    localparam logic [4:0] ALUOP_AND = 5'b00000;
    localparam logic [4:0] ALUOP_OR  = 5'b00001;
    localparam logic [4:0] ALUOP_ADD = 5'b00010;
    localparam logic [4:0] ALUOP_SUB = 5'b01110;
    localparam logic [4:0] ALUOP_SLT = 5'b01111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Unsigned carry-out of a+b recovered from the MSBs of the operands and the sum.
    function automatic logic add_carry(input logic a15, input logic b15, input logic r15);
        return (a15 & b15) | ((a15 | b15) & ~r15);
    endfunction

endpackage

// File: rtl/alu_16.sv
// Shared 16-bit ALU: aluop = {inva, invb, ci, op[1:0]}, op selects AND/OR/ADD/SLT.
module alu_16
    import alu_pkg::*;
(
    input  logic [4:0]  aluop_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] result_o,
    output logic        ovf_o
);

    logic [15:0] aa;
    logic [15:0] bb;
    logic [15:0] sum;

    always_comb begin
        aa       = aluop_i[4] ? ~a_i : a_i;
        bb       = aluop_i[3] ? ~b_i : b_i;
        sum      = aa + bb + {15'd0, aluop_i[2]};
        ovf_o    = (aa[15] == bb[15]) && (sum[15] != aa[15]);
        result_o = '0;
        case (aluop_i[1:0])
            2'b00:   result_o = aa & bb;
            2'b01:   result_o = aa | bb;
            2'b10:   result_o = sum;
            default: result_o = {15'd0, sum[15] ^ ovf_o};
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier driving the shared alu_16 adder.
// Optional early termination when remaining multiplier bits are zero: ALU_MUL_EARLY_EXIT_EN.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [4:0]         alu_aluop,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_ovf
);

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_q;
    logic               carry;
    logic               finish;
    logic               unused_ovf;

`ifdef ALU_MUL_EARLY_EXIT_EN
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   r_next;
`endif

    assign unused_ovf = alu_ovf;
    assign alu_aluop  = ALUOP_ADD;
    assign alu_a      = acc_q;
    assign product    = product_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef ALU_MUL_EARLY_EXIT_EN
            r_q       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef ALU_MUL_EARLY_EXIT_EN
            r_q       <= r_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        ready     = 1'b0;
        done      = 1'b0;
        alu_b     = '0;
        finish    = 1'b0;
`ifdef ALU_MUL_EARLY_EXIT_EN
        r_d       = r_q;
        r_next    = r_q >> 1;
`endif

        if (state_q == RUN) begin
            alu_b = q_q[0] ? m_q : '0;
        end
        // The adder result is one bit too narrow; the lost carry re-enters as the new acc MSB.
        carry    = add_carry(alu_a[WIDTH-1], alu_b[WIDTH-1], alu_result[WIDTH-1]);
        step_acc = {carry, alu_result[WIDTH-1:1]};
        step_q   = {alu_result[0], q_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    m_d       = mcand;
                    q_d       = mplier;
                    acc_d     = '0;
                    cnt_d     = '0;
                    product_d = '0;
                    state_d   = RUN;
`ifdef ALU_MUL_EARLY_EXIT_EN
                    r_d       = mplier;
`endif
                end
            end
            RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q + 5'd1;
`ifdef ALU_MUL_EARLY_EXIT_EN
                r_d    = r_next;
                finish = (cnt_q == 5'd15) || (r_next == '0);
                // Partial sum still sits high in {acc,q}; realign by the steps not taken.
                if (finish) begin
                    state_d   = DONE;
                    product_d = {step_acc, step_q} >> (4'd15 - cnt_q[3:0]);
                end
`else
                finish = (cnt_q == 5'd15);
                if (finish) begin
                    state_d   = DONE;
                    product_d = {step_acc, step_q};
                end
`endif
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq paired with alu_16, scoreboard-based.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        done;
    logic [31:0] product;
    logic [4:0]  alu_aluop;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    alu_mul_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .mcand(mcand), .mplier(mplier), .done(done), .product(product),
        .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_ovf(alu_ovf)
    );

    alu_16 u_alu (
        .aluop_i(alu_aluop), .a_i(alu_a), .b_i(alu_b),
        .result_o(alu_result), .ovf_o(alu_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [15:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
        int steps = 1;
        for (int i = 0; i < 16; i++) if (b[i]) steps = i + 1;
        return steps + 1;
`else
        return 17 + 0 * int'(b[0]);
`endif
    endfunction

    task automatic mul_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input bit noise);
        int n;
        int lat;
        bit got;
        logic [31:0] exp;
        @(negedge clk);
        chk({tag, "_ready_idle"}, {31'd0, ready}, 32'd1);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        sb.push_back({16'd0, a} * {16'd0, b});
        lat = exp_latency(b);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_prod_clr"}, product, 32'd0);
        chk({tag, "_aluop"}, {27'd0, alu_aluop}, {27'd0, ALUOP_ADD});
        n   = 1;
        got = 1'b0;
        while (n <= 40) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (noise) begin
                chk({tag, "_ready_busy"}, {31'd0, ready}, 32'd0);
                start  = 1'b1;
                mcand  = 16'($urandom);
                mplier = 16'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        chk({tag, "_latency"}, n, lat);
        exp = sb.pop_front();
        chk({tag, "_product"}, product, exp);
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
        chk({tag, "_prod_hold"}, product, exp);
    endtask

    initial begin
        int saw_done;
        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_aluop", {27'd0, alu_aluop}, 32'h2);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
        rst = 1'b0;

        mul_op("m3x5", 16'd3, 16'd5, 1'b0);
        mul_op("mffff", 16'hFFFF, 16'hFFFF, 1'b0);
        mul_op("mzero", 16'h1234, 16'h0000, 1'b0);
        mul_op("mnoise", 16'd7, 16'd9, 1'b1);

        // Abort mid-RUN: reset in the 8th RUN cycle, with a competing start.
        @(negedge clk);
        mcand  = 16'hBEEF;
        mplier = 16'h8123;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_running", {31'd0, ready}, 32'd0);
        rst    = 1'b1;
        start  = 1'b1;
        mcand  = 16'd11;
        mplier = 16'd13;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_product", product, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_idle", {31'd0, ready}, 32'd1);

        mul_op("m2x2", 16'd2, 16'd2, 1'b0);
        mul_op("mabcd", 16'hABCD, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mul_op("mrand", 16'($urandom), 16'($urandom), 1'b0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
